// File: rtl/framestore_arbiter_pkg.sv
// framestore_arbiter_pkg: shared framestore definitions (widths, FSM encodings).
package framestore_arbiter_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} arb_state_e;
  typedef enum logic [1:0] {ED_IDLE = 2'd0, ED_SCAN = 2'd1, ED_WRITE = 2'd2} ed_state_e;
endpackage

// File: rtl/framestore_arbiter_if.sv
// framestore_arbiter_if: request/ack memory port shared by masters and the framestore.
interface framestore_arbiter_if
  import framestore_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        nbyte;
  logic              rnw;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  modport master (output req, addr, nbyte, rnw, w_data, input ack, r_data);
  modport slave  (input req, addr, nbyte, rnw, w_data, output ack, r_data);
endinterface

// File: rtl/framestore_arbiter.sv
// framestore_arbiter: round-robin arbiter granting two masters one framestore port.
module framestore_arbiter
  import framestore_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  framestore_arbiter_if.slave   m0,
  framestore_arbiter_if.slave   m1,
  framestore_arbiter_if.master  fs,
  output logic                  busy,
  output logic                  grant
);
  arb_state_e        state_q, state_d;
  logic              grant_q, last_q, win, start, done;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        nbyte_q;
  logic              rnw_q;
  logic [DATA_W-1:0] wdata_q, rd0_q, rd1_q;
  always_comb begin
    state_d = state_q;
    start   = (state_q == IDLE) && (m0.req || m1.req);
    done    = (state_q == ISSUE) && fs.ack;
    win     = (m0.req && m1.req) ? ~last_q : m1.req;
    state_d = start ? ISSUE : done ? RESP : (state_q == ISSUE) ? ISSUE : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      nbyte_q <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        grant_q <= win;
        last_q  <= win;
        addr_q  <= win ? m1.addr : m0.addr;
        rnw_q   <= win ? m1.rnw : m0.rnw;
        nbyte_q <= (win ? m1.rnw : m0.rnw) ? 4'hF : (win ? m1.nbyte : m0.nbyte);
        wdata_q <= win ? m1.w_data : m0.w_data;
      end
      if (done && rnw_q && !grant_q) rd0_q <= fs.r_data;
      if (done && rnw_q && grant_q) rd1_q <= fs.r_data;
    end
  end
  assign fs.req    = (state_q == ISSUE);
  assign fs.addr   = addr_q;
  assign fs.nbyte  = nbyte_q;
  assign fs.rnw    = rnw_q;
  assign fs.w_data = wdata_q;
  assign m0.ack    = (state_q == RESP) && !grant_q;
  assign m1.ack    = (state_q == RESP) && grant_q;
  assign m0.r_data = rd0_q;
  assign m1.r_data = rd1_q;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
endmodule

// File: tb/tb_framestore_arbiter.sv
// tb_framestore_arbiter: directed vectors plus multi-cycle sequences for the arbiter.
module tb_framestore_arbiter;
  import framestore_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, grant;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  framestore_arbiter_if m0 ();
  framestore_arbiter_if m1 ();
  framestore_arbiter_if fs ();
  framestore_arbiter dut (.clk(clk), .rst(rst), .m0(m0), .m1(m1), .fs(fs), .busy(busy), .grant(grant));
  typedef struct {
    logic        m;
    logic        rnw;
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic [3:0]  exp_nbyte;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;
  vec_t tbl[5];
  vec_t post;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic m, input logic req, input logic rnw, input logic [17:0] addr,
                       input logic [3:0] nb, input logic [31:0] wd);
    if (m) begin
      m1.req = req; m1.rnw = rnw; m1.addr = addr; m1.nbyte = nb; m1.w_data = wd;
    end else begin
      m0.req = req; m0.rnw = rnw; m0.addr = addr; m0.nbyte = nb; m0.w_data = wd;
    end
  endtask
  function automatic logic ack_of(input logic m);
    return m ? m1.ack : m0.ack;
  endfunction
  function automatic logic [31:0] rd_of(input logic m);
    return m ? m1.r_data : m0.r_data;
  endfunction
  task automatic wait_issue(input string nm);
    int k = 0;
    while (!fs.req && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " fs_req"}, fs.req, 1);
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    drive(v.m, 1'b1, v.rnw, v.addr, v.nbyte, v.wd);
    @(negedge clk);
    wait_issue(nm);
    chk({nm, " grant"}, grant, v.m);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " fs_addr"}, fs.addr, v.addr);
    chk({nm, " fs_nbyte"}, fs.nbyte, v.exp_nbyte);
    chk({nm, " fs_rnw"}, fs.rnw, v.rnw);
    if (!v.rnw) chk({nm, " fs_w_data"}, fs.w_data, v.wd);
    // perturb the master's command while the transaction is in flight
    drive(v.m, 1'b1, ~v.rnw, ~v.addr, ~v.nbyte, ~v.wd);
    repeat (v.dly) begin
      @(negedge clk);
      chk({nm, " hold fs_req"}, fs.req, 1);
      chk({nm, " hold fs_addr"}, fs.addr, v.addr);
      chk({nm, " hold fs_nbyte"}, fs.nbyte, v.exp_nbyte);
      chk({nm, " hold fs_rnw"}, fs.rnw, v.rnw);
      if (!v.rnw) chk({nm, " hold fs_w_data"}, fs.w_data, v.wd);
    end
    fs.ack = 1'b1;
    fs.r_data = v.rd;
    @(negedge clk);
    fs.ack = 1'b0;
    fs.r_data = 32'hBAD0BAD0;
    chk({nm, " ack"}, ack_of(v.m), 1);
    chk({nm, " other ack"}, ack_of(~v.m), 0);
    drive(v.m, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk({nm, " ack drop"}, ack_of(v.m), 0);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " m0_r_data"}, m0.r_data, v.exp_rd0);
    chk({nm, " m1_r_data"}, m1.r_data, v.exp_rd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    fs.ack = 1'b0;
    fs.r_data = '0;
    tbl[0] = '{1'b0, 1'b1, 18'h00010, 4'h3, 32'h0,        32'hDEADBEEF, 3, 4'hF, 32'hDEADBEEF, 32'h10000005};
    tbl[1] = '{1'b1, 1'b0, 18'h3FFFF, 4'h5, 32'h12345678, 32'hAAAA5555, 1, 4'h5, 32'hDEADBEEF, 32'h10000005};
    tbl[2] = '{1'b1, 1'b1, 18'h00001, 4'h0, 32'h0,        32'hCAFEF00D, 0, 4'hF, 32'hDEADBEEF, 32'hCAFEF00D};
    tbl[3] = '{1'b0, 1'b0, 18'h20000, 4'hA, 32'h0F0F0F0F, 32'h11111111, 2, 4'hA, 32'hDEADBEEF, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 1'b1, 18'h3FFFF, 4'h0, 32'h0,        32'h00000001, 0, 4'hF, 32'h00000001, 32'hCAFEF00D};
    post   = '{1'b1, 1'b1, 18'h00005, 4'h2, 32'h0,        32'h0BADCAFE, 1, 4'hF, 32'h00000000, 32'h0BADCAFE};
    #1;
    chk("reset fs_req", fs.req, 0);
    chk("reset busy", busy, 0);
    chk("reset grant", grant, 0);
    chk("reset acks", {m0.ack, m1.ack}, 0);
    chk("reset fs_cmd", {fs.addr, fs.nbyte, fs.rnw, fs.w_data}, 0);
    chk("reset r_data", {m0.r_data, m1.r_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fs.ack = 1'b1;
    fs.r_data = 32'h55AA55AA;
    @(negedge clk);
    fs.ack = 1'b0;
    chk("spurious acks", {m0.ack, m1.ack}, 0);
    chk("spurious busy", busy, 0);
    chk("spurious fs_req", fs.req, 0);
    chk("spurious r_data", {m0.r_data, m1.r_data}, 0);
    @(negedge clk);
    chk("spurious busy later", busy, 0);
    drive(1'b0, 1'b1, 1'b1, 18'h00100, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 18'h00200, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic g;
      g = i[0];
      @(negedge clk);
      wait_issue("contend");
      chk("contend grant", grant, g);
      chk("contend fs_addr", fs.addr, g ? 18'h00200 : 18'h00100);
      fs.ack = 1'b1;
      fs.r_data = 32'h10000000 + i;
      @(negedge clk);
      fs.ack = 1'b0;
      chk("contend ack", ack_of(g), 1);
      chk("contend other ack", ack_of(~g), 0);
      chk("contend r_data", rd_of(g), 32'h10000000 + i);
      if (i == 5) begin
        m0.req = 1'b0;
        m1.req = 1'b0;
      end
    end
    @(negedge clk);
    chk("contend end busy", busy, 0);
    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 18'h00ABC, 4'h0, 32'h0);
    @(negedge clk);
    wait_issue("rst_mid");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid fs_req", fs.req, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid acks", {m0.ack, m1.ack}, 0);
    chk("rst_mid grant", grant, 0);
    chk("rst_mid r_data", {m0.r_data, m1.r_data}, 0);
    chk("rst_mid fs_addr", fs.addr, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    fs.ack = 1'b1;
    fs.r_data = 32'h00000077;
    @(negedge clk);
    fs.ack = 1'b0;
    chk("late ack acks", {m0.ack, m1.ack}, 0);
    chk("late ack busy", busy, 0);
    chk("late ack r_data", m0.r_data, 0);
    run_vec(post, "post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
